// File: rtl/kmeans_iter_ctrl.sv
// K-means iteration sequencer: streams the point memory through pipe1..pipe3,
// drains the pipeline and repeats centroid updates until convergence or the iteration limit.
module kmeans_iter_ctrl #(
  parameter int addrWidth  = 8,
  parameter int PIPE_DEPTH = 3,
  parameter int iterWidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [addrWidth:0]   num_points,
  input  logic [iterWidth-1:0] max_iter,
  output logic                 mem_rd_en,
  output logic [addrWidth-1:0] mem_addr,
  output logic                 pipe_valid,
  output logic                 accum_clear,
  output logic                 accum_valid,
  output logic                 update_start,
  input  logic                 update_done,
  input  logic                 converged,
  output logic                 busy,
  output logic                 done,
  output logic                 converged_o,
  output logic [iterWidth-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_UPDATE, S_DONE
  } state_t;

  localparam logic [addrWidth-1:0] ADDR_ONE = addrWidth'(1);
  localparam logic [addrWidth:0]   NPTS_ONE = (addrWidth + 1)'(1);
  localparam logic [iterWidth-1:0] ITER_ONE = iterWidth'(1);

  state_t                 state_q, state_d;
  logic [addrWidth-1:0]   addr_q, addr_d;
  logic [addrWidth:0]     npts_q, npts_d;
  logic [iterWidth-1:0]   maxit_q, maxit_d;
  logic [iterWidth-1:0]   iter_q, iter_d, iter_inc;
  logic                   conv_q, conv_d;
  logic [PIPE_DEPTH:0]    vld_q, vld_d;
  logic                   rd_q, clr_q, ust_q, busy_q, done_q;
  logic                   last_rd;

  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + ITER_ONE;
  // Compare in addrWidth+1 bits so a full 2^addrWidth sweep ends on address '1
  assign last_rd  = ({1'b0, addr_q} == (npts_q - NPTS_ONE));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    npts_d  = npts_q;
    maxit_d = maxit_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    vld_d   = {vld_q[PIPE_DEPTH-1:0], rd_q};
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      vld_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          npts_d  = num_points;
          maxit_d = (max_iter == '0) ? ITER_ONE : max_iter;
          iter_d  = '0;
          conv_d  = 1'b0;
          state_d = S_CLEAR;
        end
        S_CLEAR: begin
          addr_d  = '0;
          state_d = (npts_q == '0) ? S_DRAIN : S_FEED;
        end
        S_FEED: begin
          addr_d = addr_q + ADDR_ONE;
          if (last_rd) state_d = S_DRAIN;
        end
        S_DRAIN: if (vld_q == '0) state_d = S_UPDATE;
        S_UPDATE: if (update_done) begin
          iter_d  = iter_inc;
          conv_d  = converged;
          state_d = (converged || (iter_inc == maxit_q)) ? S_DONE : S_CLEAR;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      npts_q  <= '0;
      maxit_q <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      vld_q   <= '0;
      rd_q    <= 1'b0;
      clr_q   <= 1'b0;
      ust_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      npts_q  <= npts_d;
      maxit_q <= maxit_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      vld_q   <= vld_d;
      rd_q    <= (state_d == S_FEED);
      clr_q   <= (state_d == S_CLEAR);
      ust_q   <= (state_d == S_UPDATE) && (state_q != S_UPDATE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign mem_rd_en    = rd_q;
  assign mem_addr     = addr_q;
  assign pipe_valid   = vld_q[0];
  assign accum_valid  = vld_q[PIPE_DEPTH];
  assign accum_clear  = clr_q;
  assign update_start = ust_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign converged_o  = conv_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Bench for kmeans_iter_ctrl: table of whole runs scored against cycle formulas and an
// address scoreboard, plus hand-written reset, abort and stray-handshake sequences.
module tb_kmeans_iter_ctrl;

  localparam int AW = 8;
  localparam int P  = 3;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   num_points = '0;
  logic [IW-1:0] max_iter = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          pipe_valid, accum_clear, accum_valid, update_start;
  logic          update_done = 1'b0;
  logic          converged = 1'b0;
  logic          busy, done, converged_o;
  logic [IW-1:0] iter_count;

  kmeans_iter_ctrl #(.addrWidth(AW), .PIPE_DEPTH(P), .iterWidth(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_points(num_points), .max_iter(max_iter),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .pipe_valid(pipe_valid),
    .accum_clear(accum_clear), .accum_valid(accum_valid),
    .update_start(update_start), .update_done(update_done), .converged(converged),
    .busy(busy), .done(done), .converged_o(converged_o), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    int   n;
    int   mi;
    int   conv_at;   // iteration whose update reports convergence, 0 = never
    int   lat;       // update_done delay after update_start
    int   exp_iters;
    logic exp_conv;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int clr_n = 0, us_n = 0, dn_n = 0, av_n = 0, iters = 0;
    int clr_f = -1, rd_f = -1, av_f = -1, av_l = -1, us_f = -1, dn_f = -1;
    int ud_last = -1, ud_at = -1;
    logic [AW-1:0] ea, got;
    for (int it = 0; it < v.exp_iters; it++)
      for (int a = 0; a < v.n; a++) begin
        ea = AW'(a);
        exp_q.push_back(ea);
      end
    @(negedge clk);
    num_points = (AW + 1)'(v.n);
    max_iter   = IW'(v.mi);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      update_done = 1'b0;
      converged   = 1'b0;
      if (accum_clear) begin clr_n++; if (clr_f < 0) clr_f = cyc; end
      if (mem_rd_en) begin
        if (rd_f < 0) rd_f = cyc;
        if (exp_q.size() == 0) chk("extra_read", 1, 0);
        else begin
          got = exp_q.pop_front();
          chk("rd_addr", mem_addr, got);
        end
      end
      if (accum_valid) begin
        av_n++;
        if (av_f < 0) av_f = cyc;
        if (us_n == 0) av_l = cyc;
      end
      if (update_start) begin us_n++; if (us_f < 0) us_f = cyc; ud_at = cyc + v.lat; end
      if (done) begin dn_n++; if (dn_f < 0) dn_f = cyc; end
      if (cyc == ud_at) begin
        iters++;
        update_done = 1'b1;
        converged   = (iters == v.conv_at);
        ud_last     = cyc;
        ud_at       = -1;
      end
      if (dn_f >= 0 && cyc >= dn_f + 2) break;
      @(negedge clk);
    end
    update_done = 1'b0;
    converged   = 1'b0;
    chk("clear_first", clr_f, 1);
    chk("rd_first", rd_f, (v.n == 0) ? -1 : 2);
    chk("av_first", av_f, (v.n == 0) ? -1 : 3 + P);
    chk("av_last_it1", av_l, (v.n == 0) ? -1 : 2 + v.n + P);
    chk("us_first", us_f, (v.n == 0) ? 3 : v.n + P + 4);
    chk("clear_count", clr_n, v.exp_iters);
    chk("us_count", us_n, v.exp_iters);
    chk("av_count", av_n, v.n * v.exp_iters);
    chk("done_count", dn_n, 1);
    chk("done_after_ud", dn_f, ud_last + 1);
    chk("iter_count", iter_count, v.exp_iters);
    chk("converged_o", converged_o, v.exp_conv);
    chk("reads_missing", exp_q.size(), 0);
    chk("idle_after", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  rd_n, clr_n, us_n, dn_n, c_last, ab_cyc, ud_cyc, found, late;
    tbl[0] = '{n: 4,   mi: 5, conv_at: 1, lat: 2, exp_iters: 1, exp_conv: 1'b1};
    tbl[1] = '{n: 3,   mi: 3, conv_at: 0, lat: 3, exp_iters: 3, exp_conv: 1'b0};
    tbl[2] = '{n: 0,   mi: 0, conv_at: 0, lat: 1, exp_iters: 1, exp_conv: 1'b0};
    tbl[3] = '{n: 256, mi: 2, conv_at: 2, lat: 1, exp_iters: 2, exp_conv: 1'b1};
    tbl[4] = '{n: 1,   mi: 4, conv_at: 3, lat: 5, exp_iters: 3, exp_conv: 1'b1};
    tbl[5] = '{n: 7,   mi: 1, conv_at: 0, lat: 1, exp_iters: 1, exp_conv: 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs", {mem_rd_en, mem_addr, pipe_valid, accum_clear, accum_valid,
                       update_start, busy, done, converged_o, iter_count}, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset at the 5th read of a 10-point sweep
    @(negedge clk);
    num_points = 9'd10; max_iter = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (mem_rd_en && mem_addr == 8'd4) found = 1;
      else @(negedge clk);
    end
    chk("rst_fifth_read", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_feed", {mem_rd_en, mem_addr, pipe_valid, accum_clear, accum_valid,
                         update_start, busy, done, converged_o, iter_count}, 0);
    @(negedge clk);
    chk("rst_stays_idle", busy, 0);
    run_vec(tbl[0]);

    // busy-time start pulses, then abort in the second iteration's DRAIN
    rd_n = 0; clr_n = 0; us_n = 0; dn_n = 0; c_last = -1; ab_cyc = -1; ud_cyc = -1; late = 0;
    @(negedge clk);
    num_points = 9'd5; max_iter = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      update_done = 1'b0;
      converged   = 1'b0;
      abort       = 1'b0;
      if (accum_clear) clr_n++;
      if (mem_rd_en) begin rd_n++; if (rd_n == 10) c_last = cyc; end
      if (update_start) begin us_n++; ud_cyc = cyc + 1; end
      if (done) dn_n++;
      if (ab_cyc >= 0 && cyc > ab_cyc && busy) late++;
      start      = mem_rd_en;
      num_points = 9'd2;
      if (cyc == ud_cyc) update_done = 1'b1;
      if (ab_cyc >= 0 && cyc == ab_cyc + 1) begin
        chk("abort_idle", busy, 0);
        chk("abort_av_drop", accum_valid, 0);
        chk("abort_pv_drop", pipe_valid, 0);
      end
      if (c_last >= 0 && cyc == c_last + 4) begin
        chk("abort_cycle_busy", busy, 1);
        chk("abort_cycle_av", accum_valid, 1);
        abort  = 1'b1;
        ab_cyc = cyc;
      end
      if (ab_cyc >= 0 && cyc == ab_cyc + 12) break;
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; update_done = 1'b0;
    chk("abort_reached", ab_cyc >= 0, 1);
    chk("abort_clears", clr_n, 2);
    chk("abort_reads", rd_n, 10);
    chk("abort_us", us_n, 1);
    chk("abort_no_done", dn_n, 0);
    chk("abort_no_restart", late, 0);
    chk("abort_iter_keep", iter_count, 1);
    chk("abort_conv_keep", converged_o, 0);

    // stray update_done (with converged=1) during FEED
    @(negedge clk);
    num_points = 9'd6; max_iter = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    update_done = 1'b1; converged = 1'b1;
    @(negedge clk);
    update_done = 1'b0; converged = 1'b0;
    chk("stray_rd", mem_rd_en, 1);
    chk("stray_addr", mem_addr, 3);
    chk("stray_iter", iter_count, 0);
    chk("stray_conv", converged_o, 0);
    chk("stray_busy", busy, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("stray_abort_idle", busy, 0);
    chk("stray_iter_after", iter_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kmeans_iter_ctrl.md
# kmeans_iter_ctrl

Sequencer for one K-means clustering run. Streams the point memory through the distance, classify and accumulate pipeline once per iteration. Waits for the pipeline to drain, then hands off to the centroid-update stage. Repeats until the update stage reports convergence or an iteration limit is reached. Sits between the top-level host handshake and the pipe1/pipe2/pipe3 datapath.

## Interface
Parameters:
- addrWidth, 8, point-memory address width; up to 2^addrWidth points
- PIPE_DEPTH, 3, register stages from pipe1 input to the accumulator write (pipe1, pipe2, pipe3)
- iterWidth, 8, width of iteration counter and limit

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle run request; honoured only in IDLE
- abort  in  1  synchronous abort; honoured in any state except IDLE
- num_points  in  addrWidth+1  points per iteration; sampled on accepted start; 0 is legal
- max_iter  in  iterWidth  iteration limit; sampled on accepted start; 0 is treated as 1
- mem_rd_en  out  1  point-memory read strobe
- mem_addr  out  addrWidth  point-memory read address
- pipe_valid  out  1  point data at pipe1 input is valid (memory read latency 1)
- accum_clear  out  1  one-cycle pulse clearing pipe3 accumulators and counters
- accum_valid  out  1  the pipe3 accumulate stage holds a valid point this cycle
- update_start  out  1  one-cycle pulse starting the centroid update
- update_done  in  1  centroid update finished; single-cycle pulse
- converged  in  1  sampled only when update_done=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- converged_o  out  1  latched convergence result of the last run
- iter_count  out  iterWidth  completed iterations of the current or last run

## Operation
- States are IDLE, CLEAR, FEED, DRAIN, UPDATE and DONE.
- **IDLE**
  - start=1 latches num_points and max_iter (0 becomes 1).
  - It clears iter_count and converged_o, then moves to CLEAR.
- **CLEAR**
  - accum_clear=1 for exactly one cycle and the read address is reset to 0.
  - Next state is FEED. If the latched num_points=0, next state is DRAIN instead.
- **FEED**
  - mem_rd_en=1 every cycle, with mem_addr = 0, 1, …, num_points-1.
  - The read with mem_addr = num_points-1 moves the FSM to DRAIN.
  - When num_points = 2^addrWidth, the address wraps to 0 only after FEED exits; no read is issued twice.
- **Valid tracking**
  - A valid shift register vld[0..PIPE_DEPTH] is loaded with vld[0] <= mem_rd_en.
  - pipe_valid = vld[0] and accum_valid = vld[PIPE_DEPTH].
- **DRAIN**
  - Wait until every bit of vld is 0, then go to UPDATE.
- **UPDATE**
  - update_start=1 in the entry cycle only, then wait for update_done.
  - On update_done, iter_count increments and converged_o <= converged.
  - If converged=1 or the new iter_count = latched max_iter, go to DONE; otherwise go to CLEAR.
  - update_done outside UPDATE is ignored.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
  - converged_o and iter_count hold until the next accepted start.
- **start and abort**
  - start while busy is ignored.
  - abort takes priority over every transition: next state is IDLE and vld is cleared to 0.
  - No done pulse is generated on abort. iter_count and converged_o keep their current values.
  - In the abort cycle itself, outputs still reflect the current state.
- **Reset**
  - rst=1 overrides everything.
  - Next cycle: state IDLE, vld=0, and all outputs 0 (mem_addr=0, iter_count=0, converged_o=0).
- **Counters**
  - iter_count saturates at 2^iterWidth-1. It cannot exceed max_iter, so in practice it never wraps.

## Timing
- Outputs are registered, or decoded from registered state, so there are no combinational paths from inputs to outputs.
- The start-accept cycle is cycle 0:
  - accum_clear is high at cycle 1.
  - The first mem_rd_en is at cycle 2, the last at cycle 1+N.
  - pipe_valid is high for cycles 3..2+N.
  - accum_valid is high for cycles 2+PIPE_DEPTH+1 .. 1+N+PIPE_DEPTH+1.
  - The vld register is empty after cycle N+PIPE_DEPTH+2, so the FSM enters UPDATE at cycle N+PIPE_DEPTH+4 with update_start high that cycle.
- After update_done is seen at cycle U, the FSM is in CLEAR or DONE at U+1.
- Iteration overhead beyond N is PIPE_DEPTH+3 cycles plus the update latency.

## Test plan
- Reset mid-FEED:
  - Stimulus: N=10, assert rst at the 5th read.
  - Required: next cycle all outputs are 0 and state is IDLE; a new start runs cleanly from address 0.
- Single iteration, converge:
  - Stimulus: N=4, max_iter=5, converged=1 on the first update_done.
  - Required: mem_addr 0..3 on cycles 2..5, accum_valid cycles 6..9, update_start at cycle 11, done one cycle after update_done, iter_count=1, converged_o=1.
- Iteration limit:
  - Stimulus: N=3, max_iter=3, converged always 0.
  - Required: exactly 3 accum_clear pulses and 3 update_start pulses, done with iter_count=3 and converged_o=0.
- Boundary sizes:
  - Stimulus: N=0 with max_iter=0, then N=256.
  - Required for N=0: no mem_rd_en, one update_start, iter_count=1.
  - Required for N=256: addresses 0..255 each read exactly once per iteration.
- Abort during DRAIN plus start while busy:
  - Stimulus: start pulses while busy, then abort during DRAIN.
  - Required: the busy-time start pulses are ignored; on abort, IDLE the next cycle, accum_valid drops to 0 immediately after, no done pulse.
- Stray update_done:
  - Stimulus: update_done pulsed during FEED.
  - Required: no state change and no iter_count increment.
